// File: rtl/array_select_arbiter.sv
// rtl/array_select_arbiter.sv - two-source round-robin/forced arbiter feeding a one-entry array buffer
module array_select_arbiter #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [BIT_WIDTH-1:0] a_data [ROWS-1:0][COLS-1:0],
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [BIT_WIDTH-1:0] b_data [ROWS-1:0][COLS-1:0],
  input  logic                 force_en,
  input  logic                 force_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data [ROWS-1:0][COLS-1:0],
  output logic                 out_src
);

  localparam logic GRANT_B = 1'b0;
  localparam logic GRANT_A = 1'b1;

  logic last_grant;
  logic can_accept;
  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;

  // A forced override removes the other source from contention entirely.
  assign req_a = a_valid && (!force_en || force_sel);
  assign req_b = b_valid && (!force_en || !force_sel);

  assign grant_a = req_a && (!req_b || (last_grant == GRANT_B));
  assign grant_b = req_b && !grant_a;

  assign can_accept = !out_valid || out_ready;

  // Readies are held low throughout reset, not just at the next edge.
  assign a_ready = rst_n && can_accept && grant_a;
  assign b_ready = rst_n && can_accept && grant_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_src    <= 1'b0;
      last_grant <= GRANT_B;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          out_data[r][c] <= '0;
        end
      end
    end else if (a_ready) begin
      out_data   <= a_data;
      out_src    <= 1'b1;
      out_valid  <= 1'b1;
      last_grant <= GRANT_A;
    end else if (b_ready) begin
      out_data   <= b_data;
      out_src    <= 1'b0;
      out_valid  <= 1'b1;
      last_grant <= GRANT_B;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_array_select_arbiter.sv
// tb/tb_array_select_arbiter.sv - randomized and directed checks of array_select_arbiter against a transaction model
module tb_array_select_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid, a_ready, b_valid, b_ready;
  logic       force_en, force_sel, out_valid, out_ready, out_src;
  logic [3:0] a_data   [7:0][7:0];
  logic [3:0] b_data   [7:0][7:0];
  logic [3:0] out_data [7:0][7:0];

  logic       di_a_valid, di_a_ready, di_b_ready, di_out_valid, di_out_src;
  logic [7:0] di_a_data   [2:0][4:0];
  logic [7:0] di_b_data   [2:0][4:0];
  logic [7:0] di_out_data [2:0][4:0];

  array_select_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .force_en(force_en), .force_sel(force_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src)
  );

  array_select_arbiter #(.BIT_WIDTH(8), .ROWS(3), .COLS(5)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .a_valid(di_a_valid), .a_ready(di_a_ready), .a_data(di_a_data),
    .b_valid(1'b0), .b_ready(di_b_ready), .b_data(di_b_data),
    .force_en(1'b0), .force_sel(1'b0),
    .out_valid(di_out_valid), .out_ready(1'b0),
    .out_data(di_out_data), .out_src(di_out_src)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: buffer contents plus who won the last transfer.
  logic [3:0] m_data [7:0][7:0];
  bit         m_valid;
  bit         m_src;
  int         m_last;   // 1 = A, 2 = B

  function automatic void model_reset();
    m_valid = 0;
    m_src   = 0;
    m_last  = 2;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m_data[r][c] = 4'h0;
  endfunction

  // Which source the rules say is accepted right now: 0 none, 1 A, 2 B.
  function automatic int winner();
    bit want_a, want_b;
    if (!rst_n) return 0;
    if (m_valid && !out_ready) return 0;
    want_a = a_valid && (!force_en || force_sel);
    want_b = b_valid && (!force_en || !force_sel);
    if (want_a && want_b) return (m_last == 1) ? 2 : 1;
    if (want_a) return 1;
    if (want_b) return 2;
    return 0;
  endfunction

  function automatic int data_diff();
    int d = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (out_data[r][c] !== m_data[r][c]) d++;
    return d;
  endfunction

  task automatic tick();
    int w;
    w = winner();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (w == 1) begin
      m_data = a_data; m_src = 1; m_valid = 1; m_last = 1;
    end else if (w == 2) begin
      m_data = b_data; m_src = 0; m_valid = 1; m_last = 2;
    end else if (m_valid && out_ready) m_valid = 0;
    #1;
  endtask

  task automatic fill_const(input logic [3:0] av, input logic [3:0] bv);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a_data[r][c] = av;
        b_data[r][c] = bv;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        a_data[r][c] = 4'($urandom);
        b_data[r][c] = 4'($urandom);
      end
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; force_en = 0; force_sel = 0; out_ready = 0;
    di_a_valid = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    int nz;
    do_reset();
    fill_random();
    a_valid = 1;
    tick();
    a_valid = 1; b_valid = 1; out_ready = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    nz = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (out_data[r][c] !== 4'h0) nz++;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_src !== 1'b0) begin n_err++; $display("FAIL reset_src: got %0b want 0", out_src); end
    n_vec++; if (nz != 0) begin n_err++; $display("FAIL reset_data: %0d nonzero elements, want 0", nz); end
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got a=%0b b=%0b want 0 0", a_ready, b_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL reset_hold: valid=%0b a=%0b b=%0b want 0 0 0", out_valid, a_ready, b_ready); end
    rst_n = 1;
    #1;
    n_vec++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL reset_tie: got a=%0b b=%0b want 1 0", a_ready, b_ready); end
    tick();
    n_vec++; if (out_src !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL reset_first: src=%0b valid=%0b want 1 1", out_src, out_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    fill_const(4'h3, 4'hC);
    a_valid = 1; b_valid = 1; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      want = (i % 2 == 0) ? 4'h3 : 4'hC;
      n_vec++; if (out_src !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL rr_src[%0d]: got %0b want %0b", i, out_src, (i % 2 == 0)); end
      n_vec++; if (out_data[0][0] !== want || out_data[7][7] !== want || data_diff() != 0) begin n_err++; $display("FAIL rr_data[%0d]: got %h/%h want %h", i, out_data[0][0], out_data[7][7], want); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    do_reset();
    fill_random();
    a_valid = 1; out_ready = 1;
    tick();
    held = out_data[2][5];
    out_ready = 0; a_valid = 1; b_valid = 1;
    for (int i = 0; i < 5; i++) begin
      fill_random();
      #1;
      n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got a=%0b b=%0b want 0 0", i, a_ready, b_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_src !== 1'b1 || out_data[2][5] !== held || data_diff() != 0) begin n_err++; $display("FAIL bp_stable[%0d]: valid=%0b src=%0b elem=%h want 1 1 %h", i, out_valid, out_src, out_data[2][5], held); end
    end
    out_ready = 1;
    #1;
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got a=%0b b=%0b want 0 1", a_ready, b_ready); end
    tick();
    n_vec++; if (out_src !== 1'b0 || data_diff() != 0) begin n_err++; $display("FAIL bp_after: src=%0b diffs=%0d want 0 0", out_src, data_diff()); end
  endtask

  task automatic test_force();
    do_reset();
    fill_random();
    force_en = 1; force_sel = 0; a_valid = 1; b_valid = 0; out_ready = 1;
    #1;
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL force_block_a: got %0b want 0", a_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL force_empty: got %0b want 0", out_valid); end
    b_valid = 1;
    #1;
    n_vec++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL force_b_ready: got a=%0b b=%0b want 0 1", a_ready, b_ready); end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_src !== 1'b0 || data_diff() != 0) begin n_err++; $display("FAIL force_b_xfer: valid=%0b src=%0b want 1 0", out_valid, out_src); end
    force_sel = 1; a_valid = 0; b_valid = 1;
    #1;
    n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL force_block_b: got %0b want 0", b_ready); end
    force_en = 0;
  endtask

  task automatic test_drain_refill();
    logic [3:0] want;
    do_reset();
    fill_random();
    a_valid = 1; out_ready = 1;
    tick();
    fill_random();
    want = a_data[3][4];
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data[3][4] !== want || data_diff() != 0) begin n_err++; $display("FAIL refill: valid=%0b elem=%h want 1 %h", out_valid, out_data[3][4], want); end
    a_valid = 0; b_valid = 0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || out_data[3][4] !== want) begin n_err++; $display("FAIL drain: valid=%0b elem=%h want 0 %h", out_valid, out_data[3][4], want); end
  endtask

  task automatic test_data_integrity();
    int bad;
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        di_a_data[r][c] = 8'(r * 16 + c);
        di_b_data[r][c] = 8'hFF;
      end
    di_a_valid = 1;
    #1;
    n_vec++; if (di_a_ready !== 1'b1) begin n_err++; $display("FAIL di_ready: got %0b want 1", di_a_ready); end
    @(posedge clk); #1;
    di_a_valid = 0;
    bad = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (di_out_data[r][c] !== 8'(r * 16 + c)) bad++;
    n_vec++; if (bad != 0 || di_out_valid !== 1'b1 || di_out_src !== 1'b1) begin n_err++; $display("FAIL di_data: %0d bad elements, valid=%0b src=%0b want 0 1 1", bad, di_out_valid, di_out_src); end
  endtask

  task automatic test_random();
    int w;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      fill_random();
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      w = winner();
      n_vec++; if (a_ready !== (w == 1) || b_ready !== (w == 2)) begin n_err++; $display("FAIL rand_ready[%0d]: got a=%0b b=%0b want %0b %0b", i, a_ready, b_ready, (w == 1), (w == 2)); end
      tick();
      n_vec++; if (out_valid !== m_valid || out_src !== m_src || data_diff() != 0) begin n_err++; $display("FAIL rand_out[%0d]: valid=%0b src=%0b diffs=%0d want %0b %0b 0", i, out_valid, out_src, data_diff(), m_valid, m_src); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_force();
    test_drain_refill();
    test_data_integrity();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
